data_memory_ctrl: RTL and testbench
===================================

DATA_MEMORY_CTRL -- requirements
Module: data_memory_ctrl

Interface
REQ-001 SHALL have parameter DEPTH, default 256: number of 64-bit words; power of two, at least 2.
REQ-002 SHALL have parameter DW, default 64: data width in bits.
REQ-003 SHALL have parameter RD_LAT, default 1: cycles from request acceptance to response; range 1..7.
REQ-004 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst_n  input  1  reset; asynchronous, active-low.
REQ-006 SHALL have port req_valid  input  1  request present.
REQ-007 SHALL have port req_ready  output  1  request can be accepted.
REQ-008 SHALL have port icode  input  4  Y86 instruction code of the request.
REQ-009 SHALL have port valA  input  DW  store data for 4/A; address for 9/B.
REQ-010 SHALL have port valE  input  DW  address for 4/5/8/A.
REQ-011 SHALL have port valP  input  DW  store data for call (8).
REQ-012 SHALL have port resp_valid  output  1  one-cycle response strobe.
REQ-013 SHALL have port valM  output  DW  read data, valid while resp_valid is high.
REQ-014 SHALL have port dmem_error  output  1  sticky address-range error.

Function
REQ-015 SHALL accept a request on a rising edge where req_valid and req_ready are both high.
REQ-016 SHALL drive req_ready high only in state IDLE.
REQ-017 SHALL select the word address as follows: valE for icode 4/5/8/A; valA for icode 9/B; no access for any other icode.
REQ-018 SHALL treat an address as unsigned; an address of DEPTH or more (any upper bit set) SHALL be out of range.
REQ-019 SHALL perform writes on the acceptance edge: valA for 4/A, valP for 8. Out-of-range writes SHALL be dropped.
REQ-020 SHALL capture the read address at acceptance for icode 5/9/B and return memory contents as of after all previously accepted writes.
REQ-021 SHALL implement the state machine IDLE -> WAIT -> RESP -> IDLE, or IDLE -> ERR:
  - IDLE->WAIT: on acceptance; down-counter loaded with RD_LAT-1.
  - WAIT->RESP: when the counter reaches 0.
  - RESP->IDLE: always.
  - any->ERR: on acceptance of an out-of-range access.
REQ-022 SHALL assert resp_valid for exactly one cycle in RESP; the request accepted at edge t yields resp_valid high in the cycle following edge t+RD_LAT, for every icode.
REQ-023 SHALL drive valM with read data for 5/9/B, and 0 for non-reads and errors; valM SHALL hold its value outside RESP.
REQ-024 SHALL, for an out-of-range access: set dmem_error, pulse resp_valid with valM=0 after RD_LAT cycles, then remain in ERR with req_ready low until reset.
REQ-025 SHALL ignore icode, valA, valE and valP in all states other than IDLE.
REQ-026 SHALL not clear dmem_error except by reset.

Reset
REQ-027 SHALL, while rst_n is low, force: state=IDLE, counter=0, req_ready=1, resp_valid=0, valM=0, dmem_error=0.
REQ-028 SHALL, on reset mid-operation, abandon the in-flight response; a write already performed SHALL remain.
REQ-029 SHALL not initialise memory contents on reset.

Structure
REQ-030 SHALL take icode constants (IHALT, INOP, ..., IRMMOVQ=4, IMRMOVQ=5, ICALL=8, IRET=9, IPUSHQ=A, IPOPQ=B) and the FSM state encoding from the shared package y86_pkg.
REQ-031 SHALL place storage in sub-module dmem_array: DEPTH x DW, single port, synchronous write, registered read; the controller adds the remaining RD_LAT-1 pipeline stages.

Verification
REQ-032 SHALL cover, with RD_LAT=1: rmmovq valE=10 valA=0x55, then mrmovq valE=10 -> second resp_valid with valM=0x55, exactly 1 cycle after acceptance.
REQ-033 SHALL cover, with RD_LAT=3: call valE=200 valP=0x1234, then ret valA=200 -> valM=0x1234 three cycles after acceptance, with req_ready low during WAIT.
REQ-034 SHALL cover pushq valE=256 (DEPTH=256) -> dmem_error=1, valM=0 response, req_ready held low, and a following write not stored.
REQ-035 SHALL cover, with DEPTH=1024: popq valA=1000 -> read succeeds with no error; opq icode=6 -> resp_valid with valM=0 and no memory change.
REQ-036 SHALL cover rst_n pulled low during WAIT -> resp_valid never pulses, req_ready=1 immediately, and a subsequent read returns the data written before reset.

Source files
------------

// File: rtl/y86_pkg.sv
// Shared Y86 definitions: instruction codes, data-memory controller states and
// helpers that classify an icode by the memory access it performs.
package y86_pkg;

  localparam logic [3:0] IHALT   = 4'h0;
  localparam logic [3:0] INOP    = 4'h1;
  localparam logic [3:0] IRRMOVQ = 4'h2;
  localparam logic [3:0] IIRMOVQ = 4'h3;
  localparam logic [3:0] IRMMOVQ = 4'h4;
  localparam logic [3:0] IMRMOVQ = 4'h5;
  localparam logic [3:0] IOPQ    = 4'h6;
  localparam logic [3:0] IJXX    = 4'h7;
  localparam logic [3:0] ICALL   = 4'h8;
  localparam logic [3:0] IRET    = 4'h9;
  localparam logic [3:0] IPUSHQ  = 4'hA;
  localparam logic [3:0] IPOPQ   = 4'hB;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2,
    S_ERR  = 2'd3
  } ctrl_state_t;

  function automatic logic is_write_op(input logic [3:0] ic);
    return (ic == IRMMOVQ) || (ic == ICALL) || (ic == IPUSHQ);
  endfunction

  function automatic logic is_read_op(input logic [3:0] ic);
    return (ic == IMRMOVQ) || (ic == IRET) || (ic == IPOPQ);
  endfunction

  // Stack pops and ret address memory through valA; everything else uses valE.
  function automatic logic uses_vale(input logic [3:0] ic);
    return (ic == IRMMOVQ) || (ic == IMRMOVQ) || (ic == ICALL) || (ic == IPUSHQ);
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Single-port data memory: synchronous write, registered read. Contents are
// never cleared so that data survives a controller reset.
module dmem_array #(
  parameter int DEPTH = 256,
  parameter int DW    = 64,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic          rd_en,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wr_data,
  output logic [DW-1:0] rd_data
);

  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[addr] <= wr_data;
    if (rd_en) rd_data <= mem[addr];
  end

endmodule

// File: rtl/data_memory_ctrl.sv
// Y86 data-memory controller: one request at a time, fixed RD_LAT response
// latency for every icode, sticky lock-up on an out-of-range access.
module data_memory_ctrl
  import y86_pkg::*;
#(
  parameter int DEPTH  = 256,
  parameter int DW     = 64,
  parameter int RD_LAT = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [3:0]    icode,
  input  logic [DW-1:0] valA,
  input  logic [DW-1:0] valE,
  input  logic [DW-1:0] valP,
  output logic          resp_valid,
  output logic [DW-1:0] valM,
  output logic          dmem_error
);

  localparam int AW = $clog2(DEPTH);

  ctrl_state_t   state, state_nxt;
  logic [2:0]    cnt, cnt_nxt;
  logic          err_pend, err_pend_nxt;
  logic          rd_flag;
  logic          accept, is_rd, is_wr, oob;
  logic          fire_ok, fire_err;
  logic [DW-1:0] addr, wr_data, rd_data, pipe_out;

  assign req_ready = (state == S_IDLE);
  assign accept    = req_valid && req_ready;

  always_comb begin
    is_rd   = is_read_op(icode);
    is_wr   = is_write_op(icode);
    addr    = uses_vale(icode) ? valE : valA;
    wr_data = (icode == ICALL) ? valP : valA;
    oob     = (is_rd || is_wr) && (addr[DW-1:AW] != '0);
  end

  dmem_array #(.DEPTH(DEPTH), .DW(DW), .AW(AW)) u_array (
    .clk     (clk),
    .wr_en   (accept && is_wr && !oob),
    .rd_en   (accept && is_rd && !oob),
    .addr    (addr[AW-1:0]),
    .wr_data (wr_data),
    .rd_data (rd_data)
  );

  // Read pipeline: array register is stage p0, the rest are added here
  if (RD_LAT == 1) begin : g_nopipe
    assign pipe_out = rd_data;
  end else begin : g_pipe
    logic [DW-1:0] data_p [RD_LAT-1];
    always_ff @(posedge clk) begin
      data_p[0] <= rd_data;
      for (int i = 1; i < RD_LAT - 1; i++) data_p[i] <= data_p[i-1];
    end
    assign pipe_out = data_p[RD_LAT-2];
  end

  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    err_pend_nxt = err_pend;
    fire_ok      = 1'b0;
    fire_err     = 1'b0;
    case (state)
      S_IDLE: begin
        if (accept) begin
          cnt_nxt = 3'(RD_LAT - 1);
          if (oob) begin
            state_nxt    = S_ERR;
            err_pend_nxt = 1'b1;
          end else begin
            state_nxt = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (cnt == 3'd0) begin
          state_nxt = S_RESP;
          fire_ok   = 1'b1;
        end else begin
          cnt_nxt = cnt - 3'd1;
        end
      end
      S_RESP: state_nxt = S_IDLE;
      // Locked until reset; still owes the error response after RD_LAT cycles
      S_ERR: begin
        if (err_pend) begin
          if (cnt == 3'd0) begin
            fire_err     = 1'b1;
            err_pend_nxt = 1'b0;
          end else begin
            cnt_nxt = cnt - 3'd1;
          end
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      cnt        <= 3'd0;
      err_pend   <= 1'b0;
      rd_flag    <= 1'b0;
      resp_valid <= 1'b0;
      valM       <= '0;
      dmem_error <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      err_pend   <= err_pend_nxt;
      resp_valid <= fire_ok || fire_err;
      if (accept) rd_flag <= is_rd && !oob;
      if (accept && oob) dmem_error <= 1'b1;
      if (fire_ok) valM <= rd_flag ? pipe_out : '0;
      else if (fire_err) valM <= '0;
    end
  end

endmodule

// File: tb/tb_data_memory_ctrl.sv
// Scoreboard bench for data_memory_ctrl: three instances cover RD_LAT 1/3/2 and
// DEPTH 256/1024; a negedge monitor matches every response against a queue.
module tb_data_memory_ctrl;
  import y86_pkg::*;

  typedef struct {
    logic [63:0] m;
    logic        e;
    int          c;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n      [3];
  logic        req_valid  [3];
  logic        req_ready  [3];
  logic [3:0]  icode      [3];
  logic [63:0] val_a      [3];
  logic [63:0] val_e      [3];
  logic [63:0] val_p      [3];
  logic        resp_valid [3];
  logic [63:0] valm       [3];
  logic        dmem_error [3];

  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  exp_t q0[$], q1[$], q2[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  data_memory_ctrl #(.DEPTH(256), .DW(64), .RD_LAT(1)) dut0 (
    .clk(clk), .rst_n(rst_n[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .icode(icode[0]), .valA(val_a[0]), .valE(val_e[0]), .valP(val_p[0]),
    .resp_valid(resp_valid[0]), .valM(valm[0]), .dmem_error(dmem_error[0]));

  data_memory_ctrl #(.DEPTH(256), .DW(64), .RD_LAT(3)) dut1 (
    .clk(clk), .rst_n(rst_n[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .icode(icode[1]), .valA(val_a[1]), .valE(val_e[1]), .valP(val_p[1]),
    .resp_valid(resp_valid[1]), .valM(valm[1]), .dmem_error(dmem_error[1]));

  data_memory_ctrl #(.DEPTH(1024), .DW(64), .RD_LAT(2)) dut2 (
    .clk(clk), .rst_n(rst_n[2]), .req_valid(req_valid[2]), .req_ready(req_ready[2]),
    .icode(icode[2]), .valA(val_a[2]), .valE(val_e[2]), .valP(val_p[2]),
    .resp_valid(resp_valid[2]), .valM(valm[2]), .dmem_error(dmem_error[2]));

  function automatic int lat(input int d);
    case (d)
      0:       return 1;
      1:       return 3;
      default: return 2;
    endcase
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_resp(input int d);
    exp_t x;
    bit   have = 0;
    case (d)
      0: if (q0.size() != 0) begin x = q0.pop_front(); have = 1; end
      1: if (q1.size() != 0) begin x = q1.pop_front(); have = 1; end
      default: if (q2.size() != 0) begin x = q2.pop_front(); have = 1; end
    endcase
    if (!have) begin
      checks++;
      errors++;
      $display("FAIL unexpected_resp dut%0d: got valM=%h expected no response", d, valm[d]);
    end else begin
      chk($sformatf("resp_valM_dut%0d", d), valm[d], x.m);
      chk($sformatf("resp_err_dut%0d", d), 64'(dmem_error[d]), 64'(x.e));
      chk($sformatf("resp_cycle_dut%0d", d), 64'(cyc), 64'(x.c));
    end
  endtask

  always @(negedge clk) begin
    for (int d = 0; d < 3; d++)
      if (resp_valid[d] === 1'b1) check_resp(d);
  end

  task automatic issue(input int d, input logic [3:0] ic, input logic [63:0] a,
                       input logic [63:0] e, input logic [63:0] p,
                       input logic [63:0] exp_m, input logic exp_err, input bit push);
    int   n = 0;
    exp_t x;
    @(negedge clk);
    while (req_ready[d] !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      chk($sformatf("ready_timeout_dut%0d", d), 64'(req_ready[d]), 64'd1);
      return;
    end
    icode[d] = ic; val_a[d] = a; val_e[d] = e; val_p[d] = p; req_valid[d] = 1'b1;
    @(posedge clk);
    #1;
    if (push) begin
      x.m = exp_m; x.e = exp_err; x.c = cyc + lat(d);
      case (d)
        0: q0.push_back(x);
        1: q1.push_back(x);
        default: q2.push_back(x);
      endcase
    end
    @(negedge clk);
    req_valid[d] = 1'b0;
    chk($sformatf("ready_low_after_accept_dut%0d", d), 64'(req_ready[d]), 64'd0);
  endtask

  task automatic drain();
    int n = 0;
    while ((q0.size() + q1.size() + q2.size()) != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
  endtask

  initial begin
    for (int d = 0; d < 3; d++) begin
      rst_n[d] = 1'b0; req_valid[d] = 1'b0; icode[d] = INOP;
      val_a[d] = '0; val_e[d] = '0; val_p[d] = '0;
    end
    repeat (2) @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("rst_ready_dut%0d", d), 64'(req_ready[d]), 64'd1);
      chk($sformatf("rst_resp_valid_dut%0d", d), 64'(resp_valid[d]), 64'd0);
      chk($sformatf("rst_valM_dut%0d", d), valm[d], 64'd0);
      chk($sformatf("rst_dmem_error_dut%0d", d), 64'(dmem_error[d]), 64'd0);
      rst_n[d] = 1'b1;
    end

    // RD_LAT=1: store/load, top address, non-memory icode
    issue(0, IRMMOVQ, 64'h55, 64'd10, 64'h0, 64'h0, 1'b0, 1);
    issue(0, IMRMOVQ, 64'h0, 64'd10, 64'h0, 64'h55, 1'b0, 1);
    issue(0, IRMMOVQ, 64'hAB, 64'd255, 64'h0, 64'h0, 1'b0, 1);
    issue(0, IMRMOVQ, 64'h0, 64'd255, 64'h0, 64'hAB, 1'b0, 1);
    issue(0, IRMMOVQ, 64'h42, 64'd0, 64'h0, 64'h0, 1'b0, 1);
    issue(0, IRMMOVQ, 64'h777, 64'd20, 64'h0, 64'h0, 1'b0, 1);
    issue(0, IHALT, 64'h5, 64'd10, 64'h9, 64'h0, 1'b0, 1);

    // Out-of-range push locks the controller until reset
    issue(0, IPUSHQ, 64'h99, 64'd256, 64'h0, 64'h0, 1'b1, 1);
    drain();
    chk("err_sticky_dut0", 64'(dmem_error[0]), 64'd1);
    chk("err_ready_low_dut0", 64'(req_ready[0]), 64'd0);
    icode[0] = IRMMOVQ; val_e[0] = 64'd20; val_a[0] = 64'h1111; req_valid[0] = 1'b1;
    repeat (4) @(negedge clk);
    req_valid[0] = 1'b0;
    chk("err_still_set_dut0", 64'(dmem_error[0]), 64'd1);
    chk("err_still_locked_dut0", 64'(req_ready[0]), 64'd0);
    rst_n[0] = 1'b0;
    #1;
    chk("err_cleared_by_reset_dut0", 64'(dmem_error[0]), 64'd0);
    chk("ready_after_reset_dut0", 64'(req_ready[0]), 64'd1);
    @(negedge clk);
    rst_n[0] = 1'b1;
    issue(0, IMRMOVQ, 64'h0, 64'd20, 64'h0, 64'h777, 1'b0, 1);
    issue(0, IMRMOVQ, 64'h0, 64'd0, 64'h0, 64'h42, 1'b0, 1);

    // RD_LAT=3: call/ret, inputs ignored while waiting
    issue(1, ICALL, 64'hDEAD, 64'd200, 64'h1234, 64'h0, 1'b0, 1);
    issue(1, IRET, 64'd200, 64'd5, 64'h0, 64'h1234, 1'b0, 1);
    icode[1] = IRMMOVQ; val_e[1] = 64'd200; val_a[1] = 64'hBAD; req_valid[1] = 1'b1;
    chk("wait_ready_low_dut1", 64'(req_ready[1]), 64'd0);
    @(negedge clk);
    req_valid[1] = 1'b0;
    issue(1, IMRMOVQ, 64'h0, 64'd200, 64'h0, 64'h1234, 1'b0, 1);

    // Reset during WAIT: no response, write kept
    issue(1, IRMMOVQ, 64'hBEEF, 64'd31, 64'h0, 64'h0, 1'b0, 0);
    rst_n[1] = 1'b0;
    #1;
    chk("rst_wait_ready_dut1", 64'(req_ready[1]), 64'd1);
    chk("rst_wait_resp_dut1", 64'(resp_valid[1]), 64'd0);
    @(negedge clk);
    rst_n[1] = 1'b1;
    repeat (4) @(negedge clk);
    issue(1, IMRMOVQ, 64'h0, 64'd31, 64'h0, 64'hBEEF, 1'b0, 1);

    // DEPTH=1024, RD_LAT=2
    issue(2, IRMMOVQ, 64'h3E8, 64'd1000, 64'h0, 64'h0, 1'b0, 1);
    issue(2, IPOPQ, 64'd1000, 64'd7, 64'h0, 64'h3E8, 1'b0, 1);
    issue(2, IOPQ, 64'hFF, 64'd1000, 64'hFF, 64'h0, 1'b0, 1);
    issue(2, IMRMOVQ, 64'h0, 64'd1000, 64'h0, 64'h3E8, 1'b0, 1);
    issue(2, IMRMOVQ, 64'h0, 64'h8000_0000_0000_03E8, 64'h0, 64'h0, 1'b1, 1);
    drain();
    chk("err_upper_bit_dut2", 64'(dmem_error[2]), 64'd1);

    drain();
    chk("pending_responses", 64'(q0.size() + q1.size() + q2.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
